program_loader: RTL

//  Writer side of the instruction store: receives a byte-stream program image and writes
//  32-bit instruction words into the writable instruction RAM that the CPU fetch stage reads.

---
 rtl/program_loader_if.sv | 41 ++++
 rtl/program_loader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// program_loader_if
//   Bundles the byte-stream input and the instruction-RAM write side of the
//   program loader, together with its status lines.
//   Modports:
//     master - the loader itself. It receives in_data/in_valid and drives
//              in_ready, the RAM write port and the status lines.
//     slave  - the environment. It feeds the byte source and observes the
//              RAM write port and the status lines.
//   Signals:
//     in_data    [7:0]            stream byte
//     in_valid                    in_data valid
//     in_ready                    loader accepts a byte when in_valid & in_ready
//     wr_en                       RAM write strobe, one cycle per word
//     wr_addr    [ADDR_WIDTH-1:0] RAM write address
//     wr_data    [31:0]           RAM write data
//     cpu_hold                    holds the CPU in reset while high
//     load_done                   one-cycle pulse when a frame is accepted
//     load_error                  sticky flag: the last frame was rejected
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_error;

  modport master (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_error
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/program_loader.sv
// program_loader
//   Writer side of the instruction store. It takes a byte-stream program image
//   framed as HEADER, N, N*4 payload bytes (MSB first) and an optional XOR
//   checksum byte. It writes each 32-bit word into the instruction RAM at
//   BASE_ADDR + word index. An N of 0 loads 2**ADDR_WIDTH words. cpu_hold is
//   raised on the cycle after HEADER is taken, so the CPU never fetches a
//   half-written image. It drops only when a frame completes cleanly, or on
//   reset.
//   Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//     defined   - a trailing checksum byte (XOR of all payload bytes) is
//                 required. On a mismatch, load_error is set and cpu_hold
//                 stays high.
//     undefined - no checksum byte. DONE follows the last write directly, and
//                 load_error is never set.
//   Ports:
//     clock    system clock; all logic is rising-edge
//     reset_n  asynchronous, active-low reset
//     bus      program_loader_if.master (stream in, RAM write out, status)
//   All outputs are registered.
module program_loader #(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         BASE_ADDR  = 0
) (
  input logic              clock,
  input logic              reset_n,
  program_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] n_words;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic [1:0]            byte_idx;
  // Only the first three bytes of a word need holding. The fourth byte goes
  // straight into wr_data.
  logic [23:0]           asm_reg;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  logic accept;
  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      n_words        <= '0;
      word_cnt       <= '0;
      byte_idx       <= '0;
      asm_reg        <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum           <= '0;
`endif
      bus.in_ready   <= 1'b1;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= BASE;
      bus.wr_data    <= '0;
      bus.cpu_hold   <= 1'b0;
      bus.load_done  <= 1'b0;
      bus.load_error <= 1'b0;
    end else begin
      bus.load_done <= 1'b0;
      case (state)
        // DONE and ERR last one cycle. They keep listening for a HEADER, so a
        // back-to-back frame is not lost.
        IDLE, DONE, ERR: begin
          state <= IDLE;
          if (accept && (bus.in_data == HEADER)) begin
            state          <= COUNT;
            bus.cpu_hold   <= 1'b1;
            bus.load_error <= 1'b0;
          end
        end

        COUNT: begin
          if (accept) begin
            n_words  <= ADDR_WIDTH'(bus.in_data);
            word_cnt <= '0;
            byte_idx <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
            state    <= DATA;
          end
        end

        DATA: begin
          if (bus.wr_en) begin
            // This is the write cycle. in_ready was low, so no byte arrives
            // this cycle.
            bus.wr_en    <= 1'b0;
            bus.in_ready <= 1'b1;
            word_cnt     <= word_cnt + ONE;
            // The compare wraps, so N=0 ends after word 2**ADDR_WIDTH-1.
            if (word_cnt == (n_words - ONE)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state         <= CHECK;
`else
              state         <= DONE;
              bus.load_done <= 1'b1;
              bus.cpu_hold  <= 1'b0;
`endif
            end
          end else if (accept) begin
            byte_idx <= byte_idx + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.in_data;
`endif
            if (byte_idx == 2'd3) begin
              bus.wr_en    <= 1'b1;
              bus.in_ready <= 1'b0;
              bus.wr_addr  <= BASE + word_cnt;
              bus.wr_data  <= {asm_reg, bus.in_data};
            end else begin
              asm_reg <= {asm_reg[15:0], bus.in_data};
            end
          end
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            if (bus.in_data == csum) begin
              state         <= DONE;
              bus.load_done <= 1'b1;
              bus.cpu_hold  <= 1'b0;
            end else begin
              // cpu_hold stays high, so the CPU never runs a bad image.
              state          <= ERR;
              bus.load_error <= 1'b1;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
